// File: rtl/oaat_pkg.sv
// Shared constants and the one-at-a-time hash arithmetic used by every
// pipeline stage and by the final avalanche stage.
package oaat_pkg;

  localparam int HASH_W   = 32;
  localparam int MIX_SHL  = 12;
  localparam int MIX_SHR  = 3;
  localparam int FIN_SHL0 = 6;
  localparam int FIN_SHR  = 12;
  localparam int FIN_SHL1 = 12;

  // Absorb one key byte into the running hash (all ops modulo 2^32).
  function automatic logic [HASH_W-1:0] oaat_byte_step(input logic [HASH_W-1:0] h,
                                                       input logic [7:0]        b);
    logic [HASH_W-1:0] t;
    t = h + {{(HASH_W-8){1'b0}}, b};
    t = t + (t << MIX_SHL);
    t = t ^ (t >> MIX_SHR);
    return t;
  endfunction

  function automatic logic [HASH_W-1:0] oaat_final(input logic [HASH_W-1:0] h);
    logic [HASH_W-1:0] t;
    t = h + (h << FIN_SHL0);
    t = t ^ (t >> FIN_SHR);
    t = t + (t << FIN_SHL1);
    return t;
  endfunction

endpackage

// File: rtl/oaat_mix_stage.sv
// One registered byte step: hashes the most significant remaining key byte
// and forwards the rest of the key, the valid bit and the tag; holds on stall.
module oaat_mix_stage
  import oaat_pkg::*;
#(
  parameter int IN_BYTES = 6,
  parameter int TAG_W    = 8,
  localparam int OUT_KW  = (IN_BYTES > 1) ? (IN_BYTES - 1) * 8 : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  up_valid,
  input  logic [HASH_W-1:0]     up_hash,
  input  logic [IN_BYTES*8-1:0] up_key,
  input  logic [TAG_W-1:0]      up_tag,
  output logic                  valid,
  output logic [HASH_W-1:0]     hash,
  output logic [OUT_KW-1:0]     rem_key,
  output logic [TAG_W-1:0]      tag
);

  // Data registers load regardless of up_valid so bubbles stay deterministic.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      hash  <= '0;
      tag   <= '0;
    end else if (advance) begin
      valid <= up_valid;
      hash  <= oaat_byte_step(up_hash, up_key[IN_BYTES*8-1 -: 8]);
      tag   <= up_tag;
    end
  end

  if (IN_BYTES > 1) begin : g_key
    always_ff @(posedge clk) begin
      if (reset) begin
        rem_key <= '0;
      end else if (advance) begin
        rem_key <= up_key[OUT_KW-1:0];
      end
    end
  end else begin : g_no_key
    assign rem_key = '0;
  end

endmodule

// File: rtl/oaat_hash_pipe.sv
// Fully pipelined one-at-a-time hash: KEY_BYTES byte stages plus a final stage.
// Define OAAT_SEED_EN to start each key from in_seed instead of zero.
module oaat_hash_pipe
  import oaat_pkg::*;
#(
  parameter int KEY_BYTES = 6,
  parameter int OUT_W     = 32,
  parameter int TAG_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [KEY_BYTES*8-1:0] in_key,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [HASH_W-1:0]      in_seed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_hash,
  output logic [TAG_W-1:0]       out_tag
);

  logic              advance;
  logic [HASH_W-1:0] seed_h;
  logic              unused_tail;

  // The whole pipeline moves together; only a held result can stall it.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

`ifdef OAAT_SEED_EN
  assign seed_h = in_seed;
`else
  logic unused_seed;
  assign seed_h      = '0;
  assign unused_seed = ^in_seed;
`endif

  for (genvar k = 0; k < KEY_BYTES; k++) begin : g_stage
    localparam int IN_B   = KEY_BYTES - k;
    localparam int OUT_KW = (IN_B > 1) ? (IN_B - 1) * 8 : 1;

    logic              up_valid;
    logic [HASH_W-1:0] up_hash;
    logic [IN_B*8-1:0] up_key;
    logic [TAG_W-1:0]  up_tag;
    logic              valid;
    logic [HASH_W-1:0] hash;
    logic [OUT_KW-1:0] rem_key;
    logic [TAG_W-1:0]  tag;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_hash  = seed_h;
      assign up_key   = in_key;
      assign up_tag   = in_tag;
    end else begin : g_body
      assign up_valid = g_stage[k-1].valid;
      assign up_hash  = g_stage[k-1].hash;
      assign up_key   = g_stage[k-1].rem_key;
      assign up_tag   = g_stage[k-1].tag;
    end

    oaat_mix_stage #(
      .IN_BYTES (IN_B),
      .TAG_W    (TAG_W)
    ) u_mix (
      .clk      (clk),
      .reset    (reset),
      .advance  (advance),
      .up_valid (up_valid),
      .up_hash  (up_hash),
      .up_key   (up_key),
      .up_tag   (up_tag),
      .valid    (valid),
      .hash     (hash),
      .rem_key  (rem_key),
      .tag      (tag)
    );
  end

  // The last byte stage has no key left; its constant one-bit key output is discarded.
  assign unused_tail = ^g_stage[KEY_BYTES-1].rem_key;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_hash  <= '0;
      out_tag   <= '0;
    end else if (advance) begin
      out_valid <= g_stage[KEY_BYTES-1].valid;
      out_hash  <= OUT_W'(oaat_final(g_stage[KEY_BYTES-1].hash));
      out_tag   <= g_stage[KEY_BYTES-1].tag;
    end
  end

endmodule

// File: tb/tb_oaat_hash_pipe.sv
// Self-checking bench for oaat_hash_pipe: known vectors, random back-to-back
// traffic, backpressure and mid-flight reset against an arithmetic model.
module tb_oaat_hash_pipe;

  localparam int KEY_BYTES = 6;
  localparam int TAG_W     = 8;
  localparam int LAT       = KEY_BYTES + 1;
`ifdef OAAT_SEED_EN
  localparam bit SEED_EN = 1'b1;
`else
  localparam bit SEED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_key;
  logic [7:0]  in_tag;
  logic [31:0] in_seed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_hash;
  logic [7:0]  out_tag;

  logic        in_ready16;
  logic        out_valid16;
  logic [15:0] out_hash16;
  logic [7:0]  out_tag16;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [31:0] hash;
    logic [7:0]  tag;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  oaat_hash_pipe #(.KEY_BYTES(KEY_BYTES), .OUT_W(32), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .in_tag    (in_tag),
    .in_seed   (in_seed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hash  (out_hash),
    .out_tag   (out_tag)
  );

  oaat_hash_pipe #(.KEY_BYTES(KEY_BYTES), .OUT_W(16), .TAG_W(TAG_W)) dut16 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready16),
    .in_key    (in_key),
    .in_tag    (in_tag),
    .in_seed   (in_seed),
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .out_hash  (out_hash16),
    .out_tag   (out_tag16)
  );

  // Reference: h += h<<n is written as multiplication by (2^n + 1).
  function automatic logic [31:0] ref_hash(input logic [47:0] key, input logic [31:0] seed);
    logic [31:0] h;
    h = SEED_EN ? seed : 32'd0;
    for (int i = KEY_BYTES - 1; i >= 0; i--) begin
      h = h + 32'(key[i*8 +: 8]);
      h = h * 32'd4097;
      h = h ^ (h >> 3);
    end
    h = h * 32'd65;
    h = h ^ (h >> 12);
    h = h * 32'd4097;
    return h;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one key and wait (bounded) for the first out_valid; cycles counts edges.
  task automatic send_and_wait(input logic [47:0] key, input logic [7:0] tag,
                               input logic [31:0] seed, output int cycles);
    in_key   = key;
    in_tag   = tag;
    in_seed  = seed;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cycles   = 1;
    while (!out_valid && cycles < 30) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_key = '0; in_tag = '0; in_seed = '0; out_ready = 1'b0;
    repeat (3) tick();
    n_compared++;
    if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    n_compared++;
    if (out_hash !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_out_hash: got %h want 0", out_hash); end
    n_compared++;
    if (out_tag !== 8'h0) begin n_mismatched++; $display("[TB] FAIL reset_out_tag: got %h want 0", out_tag); end
    reset = 1'b0;
    tick();
    n_compared++;
    if (in_ready !== 1'b1 || in_ready16 !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL reset_in_ready: got %b/%b want 1", in_ready, in_ready16);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_latency();
    int cycles;
    send_and_wait(48'h0, 8'h3C, 32'h0, cycles);
    n_compared++;
    if (cycles != LAT) begin n_mismatched++; $display("[TB] FAIL latency: got %0d cycles want %0d", cycles, LAT); end
    n_compared++;
    if (out_hash !== 32'h0) begin n_mismatched++; $display("[TB] FAIL zero_key_hash: got %h want 00000000", out_hash); end
    n_compared++;
    if (out_tag !== 8'h3C) begin n_mismatched++; $display("[TB] FAIL zero_key_tag: got %h want 3c", out_tag); end
    tick();
    n_compared++;
    if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL no_duplicate: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_known_vector();
    int cycles;
    send_and_wait(48'h000000000001, 8'hA5, 32'h0, cycles);
    n_compared++;
    if (cycles != LAT || out_hash !== 32'h49251208) begin
      n_mismatched++; $display("[TB] FAIL vector_hash: got %h after %0d cycles want 49251208 after %0d", out_hash, cycles, LAT);
    end
    n_compared++;
    if (out_tag !== 8'hA5) begin n_mismatched++; $display("[TB] FAIL vector_tag: got %h want a5", out_tag); end
    n_compared++;
    if (out_valid16 !== 1'b1 || out_hash16 !== 16'h1208 || out_tag16 !== 8'hA5) begin
      n_mismatched++; $display("[TB] FAIL vector_out16: got v=%b %h/%h want v=1 1208/a5", out_valid16, out_hash16, out_tag16);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, first = -1, last = -1;
    exp_t e;
    exp_q.delete();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_compared++; n_mismatched++;
          $display("[TB] FAIL b2b_extra: got unexpected result %h want none", out_hash);
        end else begin
          e = exp_q.pop_front();
          n_compared++;
          if (out_hash !== e.hash || out_tag !== e.tag) begin
            n_mismatched++; $display("[TB] FAIL b2b_result%0d: got %h/%h want %h/%h", got, out_hash, out_tag, e.hash, e.tag);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (sent < 20) begin
        in_key = {16'($urandom), 32'($urandom)}; in_tag = 8'($urandom); in_seed = $urandom;
        in_valid = 1'b1;
        if (in_ready) begin
          exp_q.push_back('{hash: ref_hash(in_key, in_seed), tag: in_tag});
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    n_compared++;
    if (got != 20 || last - first != 19) begin
      n_mismatched++; $display("[TB] FAIL b2b_throughput: got %0d results over %0d cycles want 20 over 20", got, last - first + 1);
    end
  endtask

  task automatic test_stall();
    int got = 0;
    exp_t e;
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      in_key = {16'($urandom), 32'($urandom)}; in_tag = 8'($urandom); in_seed = $urandom;
      in_valid = 1'b1;
      if (in_ready) exp_q.push_back('{hash: ref_hash(in_key, in_seed), tag: in_tag});
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      in_key = {16'($urandom), 32'($urandom)}; in_tag = 8'($urandom);
      n_compared++;
      if (in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stall_in_ready: got %b want 0", in_ready); end
      n_compared++;
      if (out_valid !== 1'b1 || exp_q.size() == 0 || out_hash !== exp_q[0].hash || out_tag !== exp_q[0].tag) begin
        n_mismatched++;
        $display("[TB] FAIL stall_hold: got v=%b %h/%h want v=1 and head of %0d expected", out_valid, out_hash, out_tag, exp_q.size());
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (out_valid) begin
        n_compared++;
        if (exp_q.size() == 0) begin
          n_mismatched++; $display("[TB] FAIL stall_extra: got unexpected result %h want none", out_hash);
        end else begin
          e = exp_q.pop_front();
          if (out_hash !== e.hash || out_tag !== e.tag) begin
            n_mismatched++; $display("[TB] FAIL stall_drain%0d: got %h/%h want %h/%h", got, out_hash, out_tag, e.hash, e.tag);
          end
        end
        got++;
      end
      tick();
    end
    n_compared++;
    if (got != LAT) begin n_mismatched++; $display("[TB] FAIL stall_count: got %0d results want %0d", got, LAT); end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    int cycles;
    logic [47:0] key;
    logic [7:0]  tag;
    logic [31:0] seed;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_key = {16'($urandom), 32'($urandom)}; in_tag = 8'($urandom); in_seed = $urandom;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    n_compared++;
    if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_out_valid: got %b want 0", out_valid); end
    for (int i = 0; i < 10; i++) begin
      if (out_valid) stale++;
      tick();
    end
    n_compared++;
    if (stale != 0) begin n_mismatched++; $display("[TB] FAIL midreset_stale: got %0d results want 0", stale); end
    key = {16'($urandom), 32'($urandom)}; tag = 8'($urandom); seed = $urandom;
    send_and_wait(key, tag, seed, cycles);
    n_compared++;
    if (cycles != LAT || out_hash !== ref_hash(key, seed) || out_tag !== tag) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_next: got %h/%h after %0d cycles want %h/%h after %0d",
               out_hash, out_tag, cycles, ref_hash(key, seed), tag, LAT);
    end
    tick();
  endtask

  task automatic test_seed();
    int cycles;
    send_and_wait(48'h0, 8'h5A, 32'h1, cycles);
    n_compared++;
    if (cycles != LAT || out_hash !== ref_hash(48'h0, 32'h1)) begin
      n_mismatched++; $display("[TB] FAIL seed_hash: got %h want %h", out_hash, ref_hash(48'h0, 32'h1));
    end
    tick();
  endtask

  initial begin
    $display("[TB] oaat_hash_pipe bench start (seed feature %0d)", SEED_EN);
    test_reset();
    test_latency();
    test_known_vector();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_seed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
